// File: rtl/vera_host_regs_pkg.sv
// Shared types, register indices and pointer-step arithmetic for the VERA host register block.
`timescale 1ns/1ps
package vera_host_regs_pkg;

  typedef logic [16:0] vram_addr_t;

  localparam logic [4:0] REG_ADDR_L     = 5'h00;
  localparam logic [4:0] REG_ADDR_M     = 5'h01;
  localparam logic [4:0] REG_ADDR_H     = 5'h02;
  localparam logic [4:0] REG_DATA0      = 5'h03;
  localparam logic [4:0] REG_DATA1      = 5'h04;
  localparam logic [4:0] REG_CTRL       = 5'h05;
  localparam logic [4:0] REG_AUDIO_CTRL = 5'h1B;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_WR   = 2'd1,
    SEQ_RD   = 2'd2
  } seq_state_t;

  // One queued VRAM operation: a write-then-prefetch, or a bare prefetch.
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       is_write;
    logic [7:0] wdata;
  } vram_op_t;

  function automatic vram_addr_t incr_step(input logic [3:0] idx);
    case (idx)
      4'd0:    incr_step = 17'd0;
      4'd1:    incr_step = 17'd1;
      4'd2:    incr_step = 17'd2;
      4'd3:    incr_step = 17'd4;
      4'd4:    incr_step = 17'd8;
      4'd5:    incr_step = 17'd16;
      4'd6:    incr_step = 17'd32;
      4'd7:    incr_step = 17'd64;
      4'd8:    incr_step = 17'd128;
      4'd9:    incr_step = 17'd256;
      4'd10:   incr_step = 17'd512;
      4'd11:   incr_step = 17'd40;
      4'd12:   incr_step = 17'd80;
      4'd13:   incr_step = 17'd160;
      4'd14:   incr_step = 17'd320;
      default: incr_step = 17'd640;
    endcase
  endfunction

  // inc is ADDR_H[7:3]: [4:1] selects the step, [0] selects decrement. Wraps modulo 2^17.
  function automatic vram_addr_t next_addr(input vram_addr_t a, input logic [4:0] inc);
    next_addr = inc[0] ? (a - incr_step(inc[4:1])) : (a + incr_step(inc[4:1]));
  endfunction

endpackage

// File: rtl/vera_host_regs_if.sv
// VRAM arbiter port: request/ack handshake plus the sequencer state for observation.
`timescale 1ns/1ps
interface vera_host_regs_if;
  import vera_host_regs_pkg::*;

  // Handshake: vram_req rises with vram_write/vram_addr/vram_wrdata valid and holds them
  // stable until the arbiter returns a one-cycle vram_ack; vram_rddata is valid with that ack.
  logic       vram_req;
  logic       vram_write;
  vram_addr_t vram_addr;
  logic [7:0] vram_wrdata;
  logic       vram_ack;
  logic [7:0] vram_rddata;
  seq_state_t seq_state;

  modport master (
    output vram_req, vram_write, vram_addr, vram_wrdata, seq_state,
    input  vram_ack, vram_rddata
  );

  modport slave (
    input  vram_req, vram_write, vram_addr, vram_wrdata, seq_state,
    output vram_ack, vram_rddata
  );
endinterface

// File: rtl/vera_host_regs_bus_sync.sv
// Brings the asynchronous host strobes into clk25 and turns completed bus cycles into pulses.
`timescale 1ns/1ps
module vera_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [4:0] a,
  input  logic [7:0] d,
  output logic       commit,
  output logic [4:0] commit_a,
  output logic [7:0] commit_d,
  output logic       rd_done,
  output logic [4:0] rd_a
);

  // Each stage holds {cs_n, rd_n, wr_n}.
  logic [2:0] strb_ff [SYNC_STAGES];
  logic [2:0] first_s;
  logic [2:0] sync_s;
  logic       wr_armed;
  logic       rd_armed;

  assign first_s = strb_ff[0];
  assign sync_s  = strb_ff[SYNC_STAGES-1];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) strb_ff[i] <= 3'b111;
    end else begin
      strb_ff[0] <= {cs_n, rd_n, wr_n};
      for (int i = 1; i < SYNC_STAGES; i++) strb_ff[i] <= strb_ff[i-1];
    end
  end

  // Address/data are sampled off the fast first stage so the last value before the
  // strobe rises is what gets committed.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      commit_a <= '0;
      commit_d <= '0;
      rd_a     <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      if (!first_s[2] && !first_s[0]) begin
        commit_a <= a;
        commit_d <= d;
      end
      if (!first_s[2] && !first_s[1]) rd_a <= a;
      wr_armed <= !sync_s[0] && (wr_armed || !sync_s[2]);
      rd_armed <= !sync_s[1] && (rd_armed || !sync_s[2]);
    end
  end

  assign commit  = wr_armed && sync_s[0];
  assign rd_done = rd_armed && sync_s[1];

endmodule

// File: rtl/vera_host_regs.sv
// VERA host register file: address pointers, CTRL, audio control and the VRAM access sequencer.
`timescale 1ns/1ps
module vera_host_regs
  import vera_host_regs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              extbus_cs_n,
  input  logic              extbus_rd_n,
  input  logic              extbus_wr_n,
  input  logic [4:0]        extbus_a,
  inout  wire  [7:0]        extbus_d,
  vera_host_regs_if.master  vram,
  output logic [3:0]        audio_vol
);

  logic       commit, rd_done;
  logic [4:0] commit_a, rd_a;
  logic [7:0] commit_d;

  vera_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .cs_n     (extbus_cs_n),
    .rd_n     (extbus_rd_n),
    .wr_n     (extbus_wr_n),
    .a        (extbus_a),
    .d        (extbus_d),
    .commit   (commit),
    .commit_a (commit_a),
    .commit_d (commit_d),
    .rd_done  (rd_done),
    .rd_a     (rd_a)
  );

  vram_addr_t addr0, addr1;
  logic [4:0] inc0, inc1;
  logic       addrsel;
  logic [7:0] data0, data1;
  logic [3:0] audio_ctrl;
  logic       soft_rst;
  vram_op_t   pend;
  logic       cur_port;
  seq_state_t state, state_nxt;
  logic       start, adv, fill;

  vram_addr_t sel_addr, cur_next, rd_next;
  logic [4:0] sel_inc;
  logic       rd_port;
  logic [7:0] rd_val;

  assign sel_addr  = addrsel ? addr1 : addr0;
  assign sel_inc   = addrsel ? inc1 : inc0;
  assign cur_next  = cur_port ? next_addr(addr1, inc1) : next_addr(addr0, inc0);
  assign rd_port   = (rd_a == REG_DATA1);
  assign rd_next   = rd_port ? next_addr(addr1, inc1) : next_addr(addr0, inc0);
  assign audio_vol = audio_ctrl;
  assign vram.seq_state = state;

  always_comb begin
    rd_val = 8'h00;
    case (extbus_a)
      REG_ADDR_L:     rd_val = sel_addr[7:0];
      REG_ADDR_M:     rd_val = sel_addr[15:8];
      REG_ADDR_H:     rd_val = {sel_inc, 2'b00, sel_addr[16]};
      REG_DATA0:      rd_val = data0;
      REG_DATA1:      rd_val = data1;
      REG_CTRL:       rd_val = {7'b0, addrsel};
      REG_AUDIO_CTRL: rd_val = {4'b0, audio_ctrl};
      default:        rd_val = 8'h00;
    endcase
  end

  assign extbus_d = (rst_n && !extbus_cs_n && !extbus_rd_n) ? rd_val : 8'hzz;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    adv       = 1'b0;
    fill      = 1'b0;
    if (!soft_rst) begin
      case (state)
        SEQ_IDLE: if (pend.valid) begin
          start     = 1'b1;
          state_nxt = pend.is_write ? SEQ_WR : SEQ_RD;
        end
        SEQ_WR: if (vram.vram_ack) begin
          adv       = 1'b1;
          state_nxt = SEQ_RD;
        end
        SEQ_RD: if (vram.vram_ack) begin
          fill      = 1'b1;
          state_nxt = SEQ_IDLE;
        end
        default: state_nxt = SEQ_IDLE;
      endcase
    end else begin
      state_nxt = SEQ_IDLE;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      addr0 <= '0; addr1 <= '0; inc0 <= '0; inc1 <= '0;
      addrsel <= 1'b0; data0 <= '0; data1 <= '0; audio_ctrl <= '0;
      soft_rst <= 1'b0; pend <= '0; cur_port <= 1'b0;
      vram.vram_req <= 1'b0; vram.vram_write <= 1'b0;
      vram.vram_addr <= '0; vram.vram_wrdata <= '0;
    end else if (soft_rst) begin
      addr0 <= '0; addr1 <= '0; inc0 <= '0; inc1 <= '0;
      addrsel <= 1'b0; data0 <= '0; data1 <= '0; audio_ctrl <= '0;
      soft_rst <= 1'b0; pend <= '0; cur_port <= 1'b0;
      vram.vram_req <= 1'b0; vram.vram_write <= 1'b0;
      vram.vram_addr <= '0; vram.vram_wrdata <= '0;
    end else begin
      if (start) begin
        pend.valid       <= 1'b0;
        cur_port         <= pend.port;
        vram.vram_req    <= 1'b1;
        vram.vram_write  <= pend.is_write;
        vram.vram_addr   <= pend.port ? addr1 : addr0;
        vram.vram_wrdata <= pend.wdata;
      end
      // A completed write advances the pointer and turns straight into the prefetch.
      if (adv) begin
        if (cur_port) addr1 <= cur_next;
        else          addr0 <= cur_next;
        vram.vram_write <= 1'b0;
        vram.vram_addr  <= cur_next;
      end
      if (fill) begin
        vram.vram_req <= 1'b0;
        if (cur_port) data1 <= vram.vram_rddata;
        else          data0 <= vram.vram_rddata;
      end
      if (rd_done && (rd_a == REG_DATA0 || rd_a == REG_DATA1)) begin
        if (rd_port) addr1 <= rd_next;
        else         addr0 <= rd_next;
        pend <= '{valid: 1'b1, port: rd_port, is_write: 1'b0, wdata: 8'h00};
      end
      // Later assignments win, so a fresh commit overwrites the pending slot.
      if (commit) begin
        case (commit_a)
          REG_ADDR_L: begin
            if (addrsel) addr1[7:0] <= commit_d;
            else         addr0[7:0] <= commit_d;
            pend <= '{valid: 1'b1, port: addrsel, is_write: 1'b0, wdata: 8'h00};
          end
          REG_ADDR_M: begin
            if (addrsel) addr1[15:8] <= commit_d;
            else         addr0[15:8] <= commit_d;
            pend <= '{valid: 1'b1, port: addrsel, is_write: 1'b0, wdata: 8'h00};
          end
          REG_ADDR_H: begin
            if (addrsel) begin addr1[16] <= commit_d[0]; inc1 <= commit_d[7:3]; end
            else         begin addr0[16] <= commit_d[0]; inc0 <= commit_d[7:3]; end
            pend <= '{valid: 1'b1, port: addrsel, is_write: 1'b0, wdata: 8'h00};
          end
          REG_DATA0: pend <= '{valid: 1'b1, port: 1'b0, is_write: 1'b1, wdata: commit_d};
          REG_DATA1: pend <= '{valid: 1'b1, port: 1'b1, is_write: 1'b1, wdata: commit_d};
          REG_CTRL: begin
            addrsel  <= commit_d[0];
            soft_rst <= commit_d[7];
          end
          REG_AUDIO_CTRL: audio_ctrl <= commit_d[3:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vera_host_regs.sv
// Directed bench for vera_host_regs: host bus tasks, a VRAM arbiter model and a traffic scoreboard.
`timescale 1ns/1ps
module tb_vera_host_regs;
  import vera_host_regs_pkg::*;

  // clock / reset
  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk25 = ~clk25;

  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [4:0] bus_a = '0;
  logic [7:0] tb_d = '0;
  logic       tb_d_en = 1'b0;
  wire  [7:0] bus_d;
  logic [3:0] audio_vol;
  assign bus_d = tb_d_en ? tb_d : 8'hzz;

  vera_host_regs_if vram_bus ();

  vera_host_regs #(.SYNC_STAGES(2)) dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .extbus_cs_n (cs_n),
    .extbus_rd_n (rd_n),
    .extbus_wr_n (wr_n),
    .extbus_a    (bus_a),
    .extbus_d    (bus_d),
    .vram        (vram_bus),
    .audio_vol   (audio_vol)
  );

  // scoreboard: {write, addr[16:0], data}
  logic [25:0] exp_q[$];
  logic [25:0] act_q[$];
  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:131071];
  logic       stall = 1'b0;
  int         cnt = 0;

  // Arbiter model: ack on the second falling edge of a request, one cycle wide.
  always @(negedge clk25) begin
    if (!rst_n || vram_bus.vram_ack) begin
      vram_bus.vram_ack = 1'b0;
      cnt = 0;
    end else if (vram_bus.vram_req && !stall) begin
      if (cnt == 1) begin
        vram_bus.vram_ack = 1'b1;
        if (vram_bus.vram_write) begin
          mem[vram_bus.vram_addr] = vram_bus.vram_wrdata;
          act_q.push_back({1'b1, vram_bus.vram_addr, vram_bus.vram_wrdata});
        end else begin
          vram_bus.vram_rddata = mem[vram_bus.vram_addr];
          act_q.push_back({1'b0, vram_bus.vram_addr, 8'h00});
        end
        cnt = 0;
      end else begin
        cnt = cnt + 1;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input logic [16:0] ad);
    exp_q.push_back({1'b0, ad, 8'h00});
  endtask

  task automatic exp_wr(input logic [16:0] ad, input logic [7:0] dv);
    exp_q.push_back({1'b1, ad, dv});
  endtask

  task automatic drain_check(input string tag);
    check($sformatf("%s count", tag), 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      check(tag, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
  endtask

  // driver tasks
  task automatic bus_write(input logic [4:0] ra, input logic [7:0] rv);
    @(negedge clk25);
    bus_a = ra; tb_d = rv; tb_d_en = 1'b1;
    cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk25);
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (2) @(negedge clk25);
    tb_d_en = 1'b0;
    repeat (16) @(negedge clk25);
  endtask

  task automatic bus_read(input logic [4:0] ra, output logic [7:0] rv);
    @(negedge clk25);
    bus_a = ra;
    cs_n = 1'b0; rd_n = 1'b0;
    repeat (3) @(negedge clk25);
    rv = bus_d;
    rd_n = 1'b1; cs_n = 1'b1;
    repeat (16) @(negedge clk25);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    vram_bus.vram_ack = 1'b0;
    vram_bus.vram_rddata = 8'h00;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[0] = 8'h5A;

    repeat (3) @(negedge clk25);
    check("reset req", 32'(vram_bus.vram_req), 32'd0);
    check("reset state", 32'(vram_bus.seq_state), 32'(SEQ_IDLE));
    check("reset audio", 32'(audio_vol), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk25);

    // audio control and unmapped index
    bus_write(REG_AUDIO_CTRL, 8'h0F);
    check("audio_vol", 32'(audio_vol), 32'hF);
    bus_read(REG_AUDIO_CTRL, rv);
    check("audio read", 32'(rv), 32'h0F);
    bus_write(5'h07, 8'h55);
    bus_read(5'h07, rv);
    check("unmapped read", 32'(rv), 32'h00);
    drain_check("no traffic");

    // PSG-range writes through DATA0, step 1
    bus_write(REG_CTRL, 8'h00);
    bus_write(REG_ADDR_L, 8'hC0); exp_rd(17'h000C0);
    bus_write(REG_ADDR_M, 8'hF9); exp_rd(17'h0F9C0);
    bus_write(REG_ADDR_H, 8'h11); exp_rd(17'h1F9C0);
    bus_write(REG_DATA0, 8'h33);  exp_wr(17'h1F9C0, 8'h33); exp_rd(17'h1F9C1);
    bus_write(REG_DATA0, 8'h02);  exp_wr(17'h1F9C1, 8'h02); exp_rd(17'h1F9C2);
    bus_write(REG_DATA0, 8'h00);  exp_wr(17'h1F9C2, 8'h00); exp_rd(17'h1F9C3);
    bus_write(REG_DATA0, 8'h80);  exp_wr(17'h1F9C3, 8'h80); exp_rd(17'h1F9C4);
    drain_check("psg step1");
    bus_read(REG_ADDR_L, rv);
    check("addr_l after 4", 32'(rv), 32'hC4);

    // step 0: every write hits the same address
    bus_write(REG_ADDR_L, 8'hC2); exp_rd(17'h1F9C2);
    bus_write(REG_ADDR_M, 8'hF9); exp_rd(17'h1F9C2);
    bus_write(REG_ADDR_H, 8'h01); exp_rd(17'h1F9C2);
    for (int v = 8'hFF; v >= 8'hC0; v--) begin
      bus_write(REG_DATA0, 8'(v));
      exp_wr(17'h1F9C2, 8'(v)); exp_rd(17'h1F9C2);
    end
    drain_check("step0 writes");
    bus_read(REG_ADDR_L, rv);
    check("addr_l step0", 32'(rv), 32'hC2);
    bus_read(REG_DATA0, rv); exp_rd(17'h1F9C2);
    check("data0 prefetch", 32'(rv), 32'hC0);
    drain_check("data0 read refetch");

    // decrement through zero
    bus_write(REG_ADDR_L, 8'h00); exp_rd(17'h1F900);
    bus_write(REG_ADDR_M, 8'h00); exp_rd(17'h10000);
    bus_write(REG_ADDR_H, 8'h18); exp_rd(17'h00000);
    bus_read(REG_DATA0, rv);      exp_rd(17'h1FFFF);
    check("data0 5a", 32'(rv), 32'h5A);
    drain_check("decrement wrap");
    bus_read(REG_ADDR_L, rv); check("wrap addr_l", 32'(rv), 32'hFF);
    bus_read(REG_ADDR_M, rv); check("wrap addr_m", 32'(rv), 32'hFF);
    bus_read(REG_ADDR_H, rv); check("wrap addr_h", 32'(rv), 32'h19);

    // ADDR1 with step 40
    bus_write(REG_CTRL, 8'h01);
    bus_write(REG_ADDR_L, 8'h00); exp_rd(17'h00000);
    bus_write(REG_ADDR_M, 8'h01); exp_rd(17'h00100);
    bus_write(REG_ADDR_H, 8'hB0); exp_rd(17'h00100);
    bus_write(REG_DATA1, 8'hAA);  exp_wr(17'h00100, 8'hAA); exp_rd(17'h00128);
    drain_check("addr1 step40");
    bus_read(REG_ADDR_L, rv); check("addr1 l", 32'(rv), 32'h28);
    bus_read(REG_ADDR_M, rv); check("addr1 m", 32'(rv), 32'h01);
    bus_read(REG_ADDR_H, rv); check("addr1 h", 32'(rv), 32'hB0);
    bus_read(REG_CTRL, rv);   check("ctrl sel1", 32'(rv), 32'h01);
    bus_write(REG_CTRL, 8'h00);
    bus_read(REG_ADDR_L, rv); check("addr0 kept l", 32'(rv), 32'hFF);
    bus_read(REG_ADDR_H, rv); check("addr0 kept h", 32'(rv), 32'h19);
    drain_check("no traffic 2");

    // soft reset with a request outstanding
    stall = 1'b1;
    bus_write(REG_ADDR_L, 8'h12);
    check("stalled req", 32'(vram_bus.vram_req), 32'd1);
    bus_write(REG_CTRL, 8'h80);
    check("soft rst req", 32'(vram_bus.vram_req), 32'd0);
    check("soft rst state", 32'(vram_bus.seq_state), 32'(SEQ_IDLE));
    check("soft rst audio", 32'(audio_vol), 32'd0);
    stall = 1'b0;
    repeat (8) @(negedge clk25);
    drain_check("soft rst traffic");
    bus_read(REG_ADDR_L, rv); check("soft rst addr_l", 32'(rv), 32'h00);
    bus_read(REG_ADDR_H, rv); check("soft rst addr_h", 32'(rv), 32'h00);
    bus_read(REG_CTRL, rv);   check("soft rst ctrl", 32'(rv), 32'h00);
    bus_read(REG_DATA0, rv);  exp_rd(17'h00000);
    check("soft rst data0", 32'(rv), 32'h00);
    drain_check("soft rst refetch");

    // hardware reset with a request outstanding
    bus_write(REG_AUDIO_CTRL, 8'h07);
    check("audio 7", 32'(audio_vol), 32'h7);
    stall = 1'b1;
    bus_write(REG_ADDR_M, 8'h34);
    check("stalled req 2", 32'(vram_bus.vram_req), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk25);
    check("hw rst req", 32'(vram_bus.vram_req), 32'd0);
    check("hw rst audio", 32'(audio_vol), 32'd0);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (8) @(negedge clk25);
    drain_check("hw rst traffic");
    bus_read(REG_ADDR_M, rv); check("hw rst addr_m", 32'(rv), 32'h00);
    bus_read(REG_DATA0, rv);  exp_rd(17'h00000);
    check("hw rst data0", 32'(rv), 32'h00);
    drain_check("hw rst refetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
